// File: rtl/csr_unit_pkg.sv
// Shared types for the CSR functional unit: uop encoding, FSM states and the
// latched request record.
package C;
    localparam int XLEN    = 32;
    localparam int ROB_IDW = 6;

    // Encodings follow the Zicsr funct3 field; bit 2 marks the immediate forms.
    typedef enum logic [2:0] {
        CSR_RW  = 3'd1,
        CSR_RS  = 3'd2,
        CSR_RC  = 3'd3,
        CSR_RWI = 3'd5,
        CSR_RSI = 3'd6,
        CSR_RCI = 3'd7
    } csr_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_HEAD,
        ST_ACCESS,
        ST_RESP
    } csr_unit_state_t;

    typedef struct packed {
        csr_op_t              op;
        logic [11:0]          addr;
        logic [XLEN-1:0]      src;
        logic                 rs1_zero;
        logic                 rd_zero;
        logic [ROB_IDW-1:0]   rob_id;
    } csr_req_t;

    function automatic logic csr_is_readonly(input logic [11:0] addr);
        return addr[11:10] == 2'b11;
    endfunction
endpackage

// File: rtl/csr_if.sv
// Read/write port between the CSR unit and the CSR file; the read is combinational.
interface csr_if;
    import C::*;

    logic            rvalid;
    logic [11:0]     raddr;
    logic [XLEN-1:0] rdata;
    logic            wvalid;
    logic [11:0]     waddr;
    logic [XLEN-1:0] wdata;

    modport master (output rvalid, raddr, wvalid, waddr, wdata, input rdata);
    modport slave  (input rvalid, raddr, wvalid, waddr, wdata, output rdata);
endinterface

// File: rtl/csr_alu.sv
// Combinational decode of a latched CSR uop: read/write enables, illegal flag
// and the value to be written back into the CSR.
module csr_alu
    import C::*;
(
    input  csr_op_t         op,
    input  logic [11:0]     addr,
    input  logic [XLEN-1:0] src,
    input  logic            rs1_zero,
    input  logic            rd_zero,
    input  logic [XLEN-1:0] rdata,
    output logic            do_read,
    output logic            do_write,
    output logic            illegal,
    output logic [XLEN-1:0] new_value
);
    always_comb begin
        do_read   = 1'b1;
        do_write  = 1'b0;
        new_value = src;
        case (op)
            CSR_RW, CSR_RWI: begin
                do_read   = !rd_zero;
                do_write  = 1'b1;
                new_value = src;
            end
            // Set/clear only write when there is something to set/clear.
            CSR_RS, CSR_RSI: begin
                do_write  = op[2] ? (src != '0) : !rs1_zero;
                new_value = rdata | src;
            end
            CSR_RC, CSR_RCI: begin
                do_write  = op[2] ? (src != '0) : !rs1_zero;
                new_value = rdata & ~src;
            end
            default: ;
        endcase
    end

    assign illegal = do_write && csr_is_readonly(addr);
endmodule

// File: rtl/csr_unit.sv
// Serialised Zicsr execution unit: holds one uop until it reaches the ROB head,
// performs a single read-modify-write on the CSR file and returns the old value.
module csr_unit #(
    parameter int XLEN    = C::XLEN,
    parameter int ROB_IDW = C::ROB_IDW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush_i,
    input  logic               issue_valid_i,
    output logic               issue_ready_o,
    input  logic [2:0]         issue_op_i,
    input  logic [11:0]        issue_addr_i,
    input  logic [XLEN-1:0]    issue_rs1_i,
    input  logic [4:0]         issue_uimm_i,
    input  logic               issue_rs1_zero_i,
    input  logic               issue_rd_zero_i,
    input  logic [ROB_IDW-1:0] issue_rob_id_i,
    input  logic               rob_head_valid_i,
    input  logic [ROB_IDW-1:0] rob_head_id_i,
    csr_if.master              csr_io,
    output logic               wb_valid_o,
    input  logic               wb_ready_i,
    output logic [ROB_IDW-1:0] wb_rob_id_o,
    output logic [XLEN-1:0]    wb_data_o,
    output logic               wb_exc_o
);
    import C::*;

    csr_unit_state_t    state_reg, state_next;
    csr_req_t           req_reg;
    logic [ROB_IDW-1:0] wb_rob_id_reg;
    logic [XLEN-1:0]    wb_data_reg;
    logic               wb_exc_reg;

    logic               do_read, do_write, illegal;
    logic [XLEN-1:0]    new_value;
    logic               capture, head_match, access;

    assign capture    = (state_reg == ST_IDLE) && issue_valid_i && !flush_i;
    assign head_match = rob_head_valid_i && (rob_head_id_i == req_reg.rob_id);
    // Reset suppresses the access so a dropped uop never writes the CSR file.
    assign access     = (state_reg == ST_ACCESS) && !rst;

    csr_alu u_alu (
        .op        (req_reg.op),
        .addr      (req_reg.addr),
        .src       (req_reg.src),
        .rs1_zero  (req_reg.rs1_zero),
        .rd_zero   (req_reg.rd_zero),
        .rdata     (csr_io.rdata),
        .do_read   (do_read),
        .do_write  (do_write),
        .illegal   (illegal),
        .new_value (new_value)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:      if (capture) state_next = ST_WAIT_HEAD;
            ST_WAIT_HEAD: begin
                if (flush_i)         state_next = ST_IDLE;
                else if (head_match) state_next = ST_ACCESS;
            end
            ST_ACCESS:    state_next = ST_RESP;
            ST_RESP:      if (wb_ready_i) state_next = ST_IDLE;
            default:      state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        issue_ready_o = (state_reg == ST_IDLE) || rst;
        wb_valid_o    = (state_reg == ST_RESP) && !rst;
        wb_rob_id_o   = wb_rob_id_reg;
        wb_data_o     = wb_data_reg;
        wb_exc_o      = wb_exc_reg;
        csr_io.raddr  = req_reg.addr;
        csr_io.waddr  = req_reg.addr;
        csr_io.wdata  = new_value;
        csr_io.rvalid = access && do_read && !illegal;
        csr_io.wvalid = access && do_write && !illegal;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_reg       <= '0;
            wb_rob_id_reg <= '0;
            wb_data_reg   <= '0;
            wb_exc_reg    <= 1'b0;
        end else begin
            if (capture) begin
                req_reg.op       <= csr_op_t'(issue_op_i);
                req_reg.addr     <= issue_addr_i;
                req_reg.src      <= issue_op_i[2] ? XLEN'(issue_uimm_i) : issue_rs1_i;
                req_reg.rs1_zero <= issue_rs1_zero_i;
                req_reg.rd_zero  <= issue_rd_zero_i;
                req_reg.rob_id   <= issue_rob_id_i;
            end
            if (state_reg == ST_ACCESS) begin
                wb_rob_id_reg <= req_reg.rob_id;
                wb_data_reg   <= (do_read && !illegal) ? csr_io.rdata : '0;
                wb_exc_reg    <= illegal;
            end
        end
    end
endmodule

// File: tb/tb_csr_unit.sv
// Bench for csr_unit: a small CSR file with a free-running cycle counter,
// directed scenarios and randomised uops checked against a reference model.
module tb_csr_unit;
    import C::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        issue_valid = 1'b0;
    logic        issue_ready;
    logic [2:0]  issue_op = 3'd1;
    logic [11:0] issue_addr = '0;
    logic [31:0] issue_rs1 = '0;
    logic [4:0]  issue_uimm = '0;
    logic        issue_rs1_zero = 1'b0;
    logic        issue_rd_zero = 1'b0;
    logic [5:0]  issue_rob_id = '0;
    logic        rob_head_valid = 1'b0;
    logic [5:0]  rob_head_id = '0;
    logic        wb_valid;
    logic        wb_ready = 1'b0;
    logic [5:0]  wb_rob_id;
    logic [31:0] wb_data;
    logic        wb_exc;

    always #5 clk = ~clk;

    csr_if csr_bus ();

    csr_unit dut (
        .clk              (clk),
        .rst              (rst),
        .flush_i          (flush),
        .issue_valid_i    (issue_valid),
        .issue_ready_o    (issue_ready),
        .issue_op_i       (issue_op),
        .issue_addr_i     (issue_addr),
        .issue_rs1_i      (issue_rs1),
        .issue_uimm_i     (issue_uimm),
        .issue_rs1_zero_i (issue_rs1_zero),
        .issue_rd_zero_i  (issue_rd_zero),
        .issue_rob_id_i   (issue_rob_id),
        .rob_head_valid_i (rob_head_valid),
        .rob_head_id_i    (rob_head_id),
        .csr_io           (csr_bus),
        .wb_valid_o       (wb_valid),
        .wb_ready_i       (wb_ready),
        .wb_rob_id_o      (wb_rob_id),
        .wb_data_o        (wb_data),
        .wb_exc_o         (wb_exc)
    );

    function automatic logic [31:0] init_val(input logic [11:0] a);
        return {a, 20'h5A3C1};
    endfunction

    // CSR file: plain storage plus a cycle counter at 0xC00
    logic [31:0] csr_mem [0:4095];
    logic [31:0] cycle_cnt = '0;
    always_comb csr_bus.rdata = (csr_bus.raddr == 12'hC00) ? cycle_cnt : csr_mem[csr_bus.raddr];
    always @(posedge clk) begin
        if (csr_bus.wvalid && csr_bus.waddr == 12'hC00) cycle_cnt <= csr_bus.wdata;
        else if (rst) cycle_cnt <= '0;
        else cycle_cnt <= cycle_cnt + 32'd1;
        if (csr_bus.wvalid) csr_mem[csr_bus.waddr] <= csr_bus.wdata;
    end

    // Bus monitor
    int          r_cnt = 0, w_cnt = 0;
    logic [11:0] r_addr = '0, w_addr = '0;
    logic [31:0] r_seen = '0, w_data = '0;
    always @(negedge clk) begin
        if (csr_bus.rvalid) begin r_cnt++; r_addr = csr_bus.raddr; r_seen = csr_bus.rdata; end
        if (csr_bus.wvalid) begin w_cnt++; w_addr = csr_bus.waddr; w_data = csr_bus.wdata; end
    end

    // Reference state of every CSR the bench expects the unit to have written
    logic [31:0] ref_csr [0:4095];

    int n_vec = 0, n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic run_uop(input logic [2:0] op, input logic [11:0] addr, input logic [31:0] rs1,
                           input logic [4:0] uimm, input bit rs1z, input bit rdz,
                           input logic [5:0] rob, input int head_wait, input int wb_wait);
        int          r0, w0, lat;
        logic [31:0] old, opnd, nv, exp_wb;
        bit          rd_e, wr_e, exc_e;
        r0 = r_cnt; w0 = w_cnt;
        check_eq("ready_idle", issue_ready, 1);
        issue_op = op; issue_addr = addr; issue_rs1 = rs1; issue_uimm = uimm;
        issue_rs1_zero = rs1z; issue_rd_zero = rdz; issue_rob_id = rob;
        rob_head_valid = 1'b1; rob_head_id = rob + 6'd1;
        issue_valid = 1'b1;
        tick();
        issue_valid = 1'b0; issue_rs1 = $urandom; issue_uimm = 5'($urandom); issue_rob_id = 6'($urandom);
        check_eq("ready_busy", issue_ready, 0);
        for (int i = 0; i < head_wait; i++) begin
            rob_head_valid = 1'($urandom);
            rob_head_id    = rob_head_valid ? rob + 6'd1 : rob;
            tick();
            check_eq("wait_no_wb", wb_valid, 0);
        end
        rob_head_valid = 1'b1; rob_head_id = rob;
        lat = 0;
        do begin tick(); lat++; end while (!wb_valid && lat < 8);
        check_eq("head_to_wb_latency", lat, 2);
        rob_head_valid = 1'b0;

        // reference model of the uop
        old  = (addr == 12'hC00) ? r_seen : ref_csr[addr];
        opnd = (op inside {3'd5, 3'd6, 3'd7}) ? {27'd0, uimm} : rs1;
        case (op)
            3'd1, 3'd5: begin wr_e = 1'b1;       nv = opnd; end
            3'd2:       begin wr_e = !rs1z;      nv = old | opnd; end
            3'd6:       begin wr_e = uimm != 0;  nv = old | opnd; end
            3'd3:       begin wr_e = !rs1z;      nv = old & ~opnd; end
            default:    begin wr_e = uimm != 0;  nv = old & ~opnd; end
        endcase
        rd_e  = !((op == 3'd1 || op == 3'd5) && rdz);
        exc_e = wr_e && (addr >= 12'hC00);
        if (exc_e) begin rd_e = 1'b0; wr_e = 1'b0; end
        exp_wb = rd_e ? old : 32'd0;

        for (int i = 0; i <= wb_wait; i++) begin
            check_eq("wb_valid", wb_valid, 1);
            check_eq("wb_rob_id", wb_rob_id, rob);
            check_eq("wb_data", wb_data, exp_wb);
            check_eq("wb_exc", wb_exc, exc_e);
            check_eq("ready_in_resp", issue_ready, 0);
            if (i < wb_wait) tick();
        end
        wb_ready = 1'b1;
        issue_valid = 1'b1;
        tick();
        wb_ready = 1'b0;
        issue_valid = 1'b0;
        check_eq("wb_valid_after_hs", wb_valid, 0);
        check_eq("ready_after_hs", issue_ready, 1);
        tick();
        check_eq("no_capture_on_hs", issue_ready, 1);

        check_eq("read_count", r_cnt - r0, rd_e);
        check_eq("write_count", w_cnt - w0, wr_e);
        if (rd_e) check_eq("read_addr", r_addr, addr);
        if (wr_e) begin
            check_eq("write_addr", w_addr, addr);
            check_eq("write_data", w_data, nv);
            ref_csr[addr] = nv;
        end
    endtask

    logic [11:0] addr_tab [8] = '{12'h300, 12'h305, 12'h340, 12'hB00, 12'hB02, 12'hC02, 12'hC80, 12'h7C0};
    logic [2:0]  op_tab   [6] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7};

    initial begin
        int r0, w0;
        bit rz;
        for (int i = 0; i < 4096; i++) begin
            csr_mem[i] = init_val(12'(i));
            ref_csr[i] = init_val(12'(i));
        end

        repeat (3) tick();
        check_eq("rst_ready", issue_ready, 1);
        check_eq("rst_wb_valid", wb_valid, 0);
        check_eq("rst_wb_data", wb_data, 0);
        check_eq("rst_wb_exc", wb_exc, 0);
        check_eq("rst_wb_rob", wb_rob_id, 0);
        check_eq("rst_rvalid", csr_bus.rvalid, 0);
        check_eq("rst_wvalid", csr_bus.wvalid, 0);
        rst = 1'b0;
        repeat (10) tick();

        // read of the cycle counter without write
        run_uop(3'd2, 12'hC00, 32'd0, 5'd0, 1'b1, 1'b0, 6'd3, 0, 0);
        // write-only to minstret, then read it back
        run_uop(3'd1, 12'hB02, 32'h1234, 5'd0, 1'b0, 1'b1, 6'd4, 1, 0);
        run_uop(3'd2, 12'hB02, 32'd0, 5'd0, 1'b1, 1'b0, 6'd5, 0, 0);
        // immediate clear
        run_uop(3'd1, 12'hB00, 32'hFF, 5'd0, 1'b0, 1'b1, 6'd6, 0, 0);
        run_uop(3'd7, 12'hB00, 32'd0, 5'h1F, 1'b0, 1'b0, 6'd7, 2, 0);
        // write to read-only space
        run_uop(3'd1, 12'hC02, 32'd5, 5'd0, 1'b0, 1'b0, 6'd8, 0, 0);
        // writeback stalled four cycles
        run_uop(3'd3, 12'h300, 32'h0F0F, 5'd0, 1'b0, 1'b0, 6'd9, 0, 4);

        // flush while waiting for the head
        r0 = r_cnt; w0 = w_cnt;
        issue_op = 3'd1; issue_addr = 12'h305; issue_rs1 = 32'hABCD; issue_rob_id = 6'd7;
        issue_rs1_zero = 1'b0; issue_rd_zero = 1'b0;
        rob_head_valid = 1'b1; rob_head_id = 6'd5;
        issue_valid = 1'b1;
        tick();
        issue_valid = 1'b0;
        repeat (20) tick();
        check_eq("flush_wait_ready", issue_ready, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_eq("flush_ready", issue_ready, 1);
        rob_head_id = 6'd7;
        repeat (3) tick();
        check_eq("flush_no_read", r_cnt - r0, 0);
        check_eq("flush_no_write", w_cnt - w0, 0);
        check_eq("flush_no_wb", wb_valid, 0);

        // flush in idle blocks capture
        issue_valid = 1'b1; flush = 1'b1;
        tick();
        issue_valid = 1'b0; flush = 1'b0;
        check_eq("idle_flush_ready", issue_ready, 1);
        repeat (3) tick();
        check_eq("idle_flush_no_write", w_cnt - w0, 0);
        rob_head_valid = 1'b0;

        // reset during the access cycle drops the uop
        r0 = r_cnt; w0 = w_cnt;
        issue_op = 3'd1; issue_addr = 12'hB00; issue_rs1 = 32'hDEAD; issue_rob_id = 6'd11;
        issue_valid = 1'b1;
        tick();
        issue_valid = 1'b0;
        rob_head_valid = 1'b1; rob_head_id = 6'd11;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rob_head_valid = 1'b0;
        check_eq("rst_access_no_write", w_cnt - w0, 0);
        check_eq("rst_access_ready", issue_ready, 1);
        check_eq("rst_access_no_wb", wb_valid, 0);
        tick();

        // randomised uops
        for (int n = 0; n < 60; n++) begin
            logic [2:0]  op;
            logic [11:0] ad;
            op = op_tab[$urandom_range(0, 5)];
            ad = addr_tab[$urandom_range(0, 7)];
            rz = ($urandom_range(0, 3) == 0);
            run_uop(op, ad, rz ? 32'd0 : $urandom, ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                    rz, ($urandom_range(0, 3) == 0), 6'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/csr_unit.md
Name: csr_unit

Overview:
- Functional unit that executes Zicsr uops (CSRRW/CSRRS/CSRRC and immediate forms) for the out-of-order core.
- Sits between issue and the CSR file. Holds one CSR uop until it is the oldest ROB entry, then performs one read-modify-write through csr_if.
- Returns the old CSR value, or an illegal-instruction flag, to writeback.
- Serialised: one uop in flight.

Parameters:
- XLEN, C::XLEN, datapath width.
- ROB_IDW, C::ROB_IDW, width of a ROB index.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- flush_i  in  1  pipeline flush (mispredict/exception)
- issue_valid_i  in  1  CSR uop offered
- issue_ready_o  out  1  unit can accept a uop
- issue_op_i  in  3  csr_op_t: RW, RS, RC, RWI, RSI, RCI
- issue_addr_i  in  12  CSR address
- issue_rs1_i  in  XLEN  rs1 operand (register forms)
- issue_uimm_i  in  5  zimm (immediate forms)
- issue_rs1_zero_i  in  1  rs1 field == x0
- issue_rd_zero_i  in  1  rd field == x0
- issue_rob_id_i  in  ROB_IDW  ROB tag of the uop
- rob_head_valid_i  in  1  ROB head entry valid
- rob_head_id_i  in  ROB_IDW  ROB head tag
- csr_io  csr_if.master  -  rvalid/raddr/rdata, wvalid/waddr/wdata to the CSR file
- wb_valid_o  out  1  result available
- wb_ready_i  in  1  writeback accepts
- wb_rob_id_o  out  ROB_IDW  tag of result
- wb_data_o  out  XLEN  old CSR value (0 if not read)
- wb_exc_o  out  1  illegal CSR access

Behaviour:
- States: IDLE, WAIT_HEAD, ACCESS, RESP. Reset puts the FSM in IDLE.
- Output values in reset:
  - wb_valid_o=0, wb_data_o=0, wb_exc_o=0, wb_rob_id_o=0.
  - csr_io.rvalid=0, csr_io.wvalid=0, issue_ready_o=1.
- IDLE:
  - issue_ready_o=1.
  - On issue_valid_i && !flush_i, latch all issue fields and go to WAIT_HEAD.
- WAIT_HEAD:
  - issue_ready_o=0.
  - When rob_head_valid_i && rob_head_id_i==latched rob_id, go to ACCESS. The earliest transition is the cycle after capture.
- Decode, from latched fields:
  - do_read = !(op in {RW,RWI} && rd_zero).
  - src = rs1 for register forms; zero-extended uimm for immediate forms.
  - do_write = op in {RW,RWI}, or (op in {RS,RC} && !rs1_zero), or (op in {RSI,RCI} && uimm!=0).
  - illegal = do_write && addr[11:10]==2'b11 (read-only space, e.g. 0xC00 cycle, 0xC02 instret).
- ACCESS (exactly one cycle):
  - raddr=waddr=addr; rvalid=do_read.
  - The read is combinational: rdata is sampled this cycle into the result register. If !do_read, the result is 0.
  - new = src (RW*), rdata|src (RS*), rdata&~src (RC*).
  - wvalid = do_write && !illegal; wdata = new.
  - If illegal: rvalid=0, wvalid=0, result=0, exc=1.
  - Go to RESP.
- RESP:
  - wb_valid_o=1 with rob_id/data/exc held stable until wb_ready_i.
  - On handshake, go to IDLE. No new uop is accepted in the same cycle.
- flush_i:
  - In IDLE it blocks capture.
  - In WAIT_HEAD it returns to IDLE with no CSR access.
  - Ignored in ACCESS and RESP, because a uop at the ROB head is never flushed.
- Width: all arithmetic is at XLEN. uimm is zero-extended; no sign extension anywhere.
- At most one read and one write per uop, both issued in the same cycle. The write is visible in the CSR file from the next cycle. A user write overrides the free-running counter increment in that cycle.
- rst in any state returns to IDLE next cycle. A pending uop is dropped and no CSR write is issued in that cycle.

Decomposition:
- In package C:
  - csr_op_t enum.
  - csr_unit_state_t enum.
  - csr_req_t packed struct (op, addr, src, rs1_zero, rd_zero, rob_id).
  - Function csr_is_readonly(addr).
- Sub-module csr_alu: combinational new-value / do_read / do_write / illegal decode. Unit-testable alone.

Test Plan:
- CSRRS rd=x5, rs1=x0, addr 0xC00, issued while head matches, after reset plus 10 cycles -> rvalid for 1 cycle, wvalid=0; wb_data equals csr_io.rdata sampled that cycle (cycle count, ~11); exc=0.
- CSRRW rd=x0, rs1=0x1234, addr 0xB02 (minstret) -> rvalid=0, wvalid=1 with wdata=0x1234; wb_data=0; a following CSRRS of 0xB02 returns 0x1234 plus retired count.
- CSRRCI zimm=0x1F on 0xB00 holding 0xFF -> wdata=0xE0; wb_data=0xFF.
- CSRRW to 0xC02 with rs1=5 -> no rvalid, no wvalid; wb_exc=1, wb_data=0.
- Uop with rob_id=7 waits while head=5 for 20 cycles, then flush_i -> IDLE; no csr_io activity; issue_ready_o=1 next cycle.
- wb_ready_i held low 4 cycles in RESP -> wb outputs stable; issue_ready_o=0 throughout; back to IDLE the cycle after the handshake.
